// File: rtl/note_sequencer.sv
// Note ROM sequencer: fetches {half_period, duration} words and turns each
// note into a square-wave sample stream for the PWM stage, all on the audio clock.
module note_sequencer #(
    parameter int          ADDR_W   = 8,
    parameter int          TICK_DIV = 1024,
    parameter logic [31:0] AMP      = 32'h0000_FFFF,
    parameter bit          LOOP     = 1'b1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [31:0]       rom_data,
    output logic [31:0]       sample_o,
    output logic              tone,
    output logic              busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_PLAY  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [15:0]       TICK_RELOAD = 16'(TICK_DIV - 1);
    localparam logic [ADDR_W-1:0] ADDR_ZERO   = '0;
    localparam logic [ADDR_W-1:0] ADDR_ONE    = ADDR_W'(1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic              tone_q, tone_d;
    logic [15:0]       hp_q, hp_d;
    logic [15:0]       phase_cnt_q, phase_cnt_d;
    logic [15:0]       tick_cnt_q, tick_cnt_d;
    logic [15:0]       dur_cnt_q, dur_cnt_d;

    logic [15:0] word_hp;
    logic [15:0] word_dur;
    logic        tick_wrap;
    logic        note_end;

    assign word_hp   = rom_data[31:16];
    assign word_dur  = rom_data[15:0];
    assign tick_wrap = (tick_cnt_q == 16'd0);
    assign note_end  = tick_wrap && (dur_cnt_q == 16'd1);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            rom_addr_q  <= '0;
            tone_q      <= 1'b0;
            hp_q        <= '0;
            phase_cnt_q <= '0;
            tick_cnt_q  <= '0;
            dur_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            rom_addr_q  <= rom_addr_d;
            tone_q      <= tone_d;
            hp_q        <= hp_d;
            phase_cnt_q <= phase_cnt_d;
            tick_cnt_q  <= tick_cnt_d;
            dur_cnt_q   <= dur_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        rom_addr_d  = rom_addr_q;
        tone_d      = tone_q;
        hp_d        = hp_q;
        phase_cnt_d = phase_cnt_q;
        tick_cnt_d  = tick_cnt_q;
        dur_cnt_d   = dur_cnt_q;

        if (!en) begin
            // Dropping enable wins over everything and rewinds the song.
            state_d     = ST_IDLE;
            rom_addr_d  = '0;
            tone_d      = 1'b0;
            hp_d        = '0;
            phase_cnt_d = '0;
            tick_cnt_d  = '0;
            dur_cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d    = ST_FETCH;
                    rom_addr_d = '0;
                    tone_d     = 1'b0;
                end

                ST_FETCH: begin
                    hp_d = word_hp;
                    if (word_dur != 16'd0) begin
                        state_d     = ST_PLAY;
                        phase_cnt_d = word_hp - 16'd1;
                        tick_cnt_d  = TICK_RELOAD;
                        dur_cnt_d   = word_dur;
                        tone_d      = (word_hp != 16'd0);
                    end else if (LOOP && (rom_addr_q != ADDR_ZERO)) begin
                        rom_addr_d = '0;
                        tone_d     = 1'b0;
                    end else begin
                        state_d = ST_DONE;
                        tone_d  = 1'b0;
                    end
                end

                ST_PLAY: begin
                    if (hp_q != 16'd0) begin
                        if (phase_cnt_q == 16'd0) begin
                            tone_d      = ~tone_q;
                            phase_cnt_d = hp_q - 16'd1;
                        end else begin
                            phase_cnt_d = phase_cnt_q - 16'd1;
                        end
                    end

                    if (tick_wrap) begin
                        tick_cnt_d = TICK_RELOAD;
                        dur_cnt_d  = dur_cnt_q - 16'd1;
                    end else begin
                        tick_cnt_d = tick_cnt_q - 16'd1;
                    end

                    // The end of the last tick overrides any phase toggle.
                    if (note_end) begin
                        state_d    = ST_FETCH;
                        rom_addr_d = rom_addr_q + ADDR_ONE;
                        tone_d     = 1'b0;
                    end
                end

                ST_DONE: begin
                    tone_d = 1'b0;
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign rom_addr = rom_addr_q;
    assign tone     = tone_q;
    assign sample_o = tone_q ? AMP : 32'd0;
    assign busy     = (state_q == ST_FETCH) || (state_q == ST_PLAY);

endmodule
